// File: rtl/apb_slave_if.sv
// ----------------------------------------------------------------------------
// apb_slave_if -- APB bus signal bundle between one master and apb_slave.
//
// Parameters
//   AWIDTH  address width in bits
//   DWIDTH  data width in bits
//
// Signals
//   psel     master -> slave  slave select
//   penable  master -> slave  access-phase strobe
//   pwrite   master -> slave  1 = write, 0 = read
//   paddr    master -> slave  register address
//   pwdata   master -> slave  write data
//   prdata   slave -> master  registered read data
//   pready   slave -> master  transfer complete
//   pslverr  slave -> master  error response, meaningful only while pready=1
//
// Modports: master (drives requests), slave (drives responses).
// ----------------------------------------------------------------------------
interface apb_slave_if #(
    parameter int AWIDTH = 4,
    parameter int DWIDTH = 8
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [AWIDTH-1:0] paddr;
    logic [DWIDTH-1:0] pwdata;
    logic [DWIDTH-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave.sv
// ----------------------------------------------------------------------------
// apb_slave -- APB register-file slave with NUM_REGS registers of DWIDTH bits.
//
// Parameters
//   AWIDTH    address width in bits (default 4)
//   DWIDTH    data width in bits (default 8)
//   NUM_REGS  implemented registers, addresses 0..NUM_REGS-1 (1..2^AWIDTH)
//
// Ports
//   pclk     in   single clock, rising edge
//   presetn  in   asynchronous active-low reset
//   bus      slave modport of apb_slave_if (psel/penable/pwrite/paddr/pwdata
//                 in, prdata/pready/pslverr out)
//   state_o  out  current FSM state for observation (0=IDLE, 1=ACCESS, 2=WAIT)
//
// Configuration macro
//   APB_SLAVE_WAIT_EN  when defined, every transfer passes through a one-cycle
//                      WAIT state (3 cycles per transfer); when undefined the
//                      WAIT state does not exist (2 cycles per transfer).
//
// Handshake: a transfer starts with a setup phase (psel=1, penable=0) seen in
// IDLE; it completes at the edge where the slave is in ACCESS (pready=1) and
// the master holds psel=1, penable=1. Dropping psel or penable before that
// edge aborts the transfer with no side effects.
// ----------------------------------------------------------------------------
module apb_slave #(
    parameter int AWIDTH   = 4,
    parameter int DWIDTH   = 8,
    parameter int NUM_REGS = 12
) (
    input  logic        pclk,
    input  logic        presetn,
    apb_slave_if.slave  bus,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1
`ifdef APB_SLAVE_WAIT_EN
        ,
        S_WAIT   = 2'd2
`endif
    } state_t;

    // One extra bit so NUM_REGS = 2^AWIDTH is representable.
    localparam logic [AWIDTH:0] REG_LIMIT = (AWIDTH+1)'(NUM_REGS);

    state_t            state_q, state_d;
    logic [AWIDTH-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [DWIDTH-1:0] wdata_q, wdata_d;
    logic              addr_err_q, addr_err_d;
    logic [DWIDTH-1:0] prdata_q, prdata_d;
    logic [DWIDTH-1:0] regs_q [NUM_REGS];

    logic              setup_phase;
    logic              access_hold;
    logic              addr_err_in;
    logic              reg_we;

    assign setup_phase = (state_q == S_IDLE) && bus.psel && !bus.penable;
    assign access_hold = bus.psel && bus.penable;
    assign addr_err_in = ({1'b0, bus.paddr} >= REG_LIMIT);
    // Out-of-range addresses never reach the array, so no aliasing occurs.
    assign reg_we      = (state_q == S_ACCESS) && access_hold && write_q && !addr_err_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                // penable=1 without a prior setup phase is ignored here.
                if (bus.psel && !bus.penable) begin
`ifdef APB_SLAVE_WAIT_EN
                    state_d = S_WAIT;
`else
                    state_d = S_ACCESS;
`endif
                end
            end
`ifdef APB_SLAVE_WAIT_EN
            S_WAIT:   state_d = access_hold ? S_ACCESS : S_IDLE;
`endif
            // Completion and abort both return to IDLE; only the write differs.
            S_ACCESS: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs (decoded from state only) ----------------
    always_comb begin
        bus.pready  = (state_q == S_ACCESS);
        bus.pslverr = (state_q == S_ACCESS) && addr_err_q;
        bus.prdata  = prdata_q;
        state_o     = state_q;
    end

    // ---------------- Setup-phase capture ----------------
    always_comb begin
        addr_d     = addr_q;
        write_d    = write_q;
        wdata_d    = wdata_q;
        addr_err_d = addr_err_q;
        prdata_d   = prdata_q;
        if (setup_phase) begin
            addr_d     = bus.paddr;
            write_d    = bus.pwrite;
            wdata_d    = bus.pwdata;
            addr_err_d = addr_err_in;
            // Read data is fetched at setup and held until the next read setup.
            if (!bus.pwrite) begin
                prdata_d = addr_err_in ? '0 : regs_q[bus.paddr];
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            addr_q     <= '0;
            write_q    <= 1'b0;
            wdata_q    <= '0;
            addr_err_q <= 1'b0;
            prdata_q   <= '0;
        end else begin
            addr_q     <= addr_d;
            write_q    <= write_d;
            wdata_q    <= wdata_d;
            addr_err_q <= addr_err_d;
            prdata_q   <= prdata_d;
        end
    end

    // ---------------- Register file ----------------
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (reg_we) begin
            regs_q[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_slave.sv
// ----------------------------------------------------------------------------
// tb_apb_slave -- directed bench for apb_slave with a read-data scoreboard.
// ----------------------------------------------------------------------------
module tb_apb_slave;
    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NR = 12;
`ifdef APB_SLAVE_WAIT_EN
    localparam int XFER_CYC = 3;
`else
    localparam int XFER_CYC = 2;
`endif

    // ---------------- clock / reset ----------------
    logic pclk = 1'b0;
    logic presetn;
    always #5 pclk = ~pclk;

    apb_slave_if #(.AWIDTH(AW), .DWIDTH(DW)) bus ();
    logic [1:0] state_o;

    apb_slave #(.AWIDTH(AW), .DWIDTH(DW), .NUM_REGS(NR)) dut (
        .pclk    (pclk),
        .presetn (presetn),
        .bus     (bus),
        .state_o (state_o)
    );

    // ---------------- scoreboard / model ----------------
    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] model_regs [NR];
    logic [DW-1:0] last_rd;
    logic [DW:0]   exp_q [$];   // {expected pslverr, expected prdata}

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NR; i++) model_regs[i] = '0;
        last_rd = '0;
    endtask

    // Runs one full transfer starting just after a falling edge; returns just
    // after the falling edge following completion with the bus idle, so a
    // following call issues its setup phase back-to-back.
    task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        logic        err;
        logic [DW:0] exp;
        int          cyc;
        err = (int'(addr) >= NR);
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = wr;
        bus.paddr   = addr;
        bus.pwdata  = data;
        if (!wr) begin
            if (err) exp = {1'b1, {DW{1'b0}}};
            else     exp = {1'b0, model_regs[addr]};
            exp_q.push_back(exp);
            last_rd = exp[DW-1:0];
        end
        @(negedge pclk);
        bus.penable = 1'b1;
        cyc = 2;
        while (bus.pready !== 1'b1 && cyc < 8) begin
            @(negedge pclk);
            cyc++;
        end
        check("xfer_cycles", cyc, XFER_CYC);
        if (!wr) begin
            exp = exp_q.pop_front();
            check("rd_prdata", bus.prdata, exp[DW-1:0]);
            check("rd_pslverr", bus.pslverr, exp[DW]);
        end else begin
            check("wr_pslverr", bus.pslverr, err);
            check("wr_prdata_hold", bus.prdata, last_rd);
            if (!err) model_regs[addr] = data;
        end
        @(negedge pclk);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        check("pready_one_cycle", bus.pready, 1'b0);
        check("state_back_idle", state_o, 2'd0);
    endtask

    // Drives setup, then waits for ACCESS (bounded), leaving the bus in ACCESS.
    task automatic start_write_to_access(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int cyc;
        bus.psel    = 1'b1;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b1;
        bus.paddr   = addr;
        bus.pwdata  = data;
        @(negedge pclk);
        bus.penable = 1'b1;
        cyc = 2;
        while (bus.pready !== 1'b1 && cyc < 8) begin
            @(negedge pclk);
            cyc++;
        end
        check("reach_access", bus.pready, 1'b1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        presetn     = 1'b0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        bus.pwrite  = 1'b0;
        bus.paddr   = '0;
        bus.pwdata  = '0;
        model_reset();

        repeat (2) @(negedge pclk);
        check("rst_state", state_o, 2'd0);
        check("rst_pready", bus.pready, 1'b0);
        check("rst_pslverr", bus.pslverr, 1'b0);
        check("rst_prdata", bus.prdata, 8'h00);
        // Setup driven together with reset release: first edge must take it.
        presetn = 1'b1;

        // Basic write then read back.
        xfer(1'b1, 4'd3, 8'hA5);
        xfer(1'b0, 4'd3, 8'h00);

        // Out-of-range address: error on both, no aliasing, nothing written.
        xfer(1'b1, 4'd13, 8'hFF);
        xfer(1'b0, 4'd13, 8'h00);
        for (int a = 0; a < NR; a++) xfer(1'b0, AW'(a), 8'h00);

        // Back-to-back writes then reads over the whole map.
        for (int a = 0; a < NR; a++) xfer(1'b1, AW'(a), DW'(a + 1));
        for (int a = 0; a < NR; a++) xfer(1'b0, AW'(a), 8'h00);
        // Topmost out-of-range address as well.
        xfer(1'b0, 4'd15, 8'h00);

        // Abort: psel dropped in ACCESS; reg 5 must keep its value.
        start_write_to_access(4'd5, 8'h3C);
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(negedge pclk);
        check("abort_state_idle", state_o, 2'd0);
        check("abort_pready", bus.pready, 1'b0);
        check("abort_pslverr", bus.pslverr, 1'b0);
        xfer(1'b0, 4'd5, 8'h00);

        // Reset during ACCESS: outputs clear at once, write is discarded.
        start_write_to_access(4'd2, 8'h77);
        #1;
        presetn     = 1'b0;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        #1;
        check("midrst_pready", bus.pready, 1'b0);
        check("midrst_pslverr", bus.pslverr, 1'b0);
        check("midrst_prdata", bus.prdata, 8'h00);
        check("midrst_state", state_o, 2'd0);
        model_reset();
        @(negedge pclk);
        presetn = 1'b1;
        xfer(1'b0, 4'd2, 8'h00);
        xfer(1'b0, 4'd5, 8'h00);

        // penable without a setup phase is ignored.
        bus.psel    = 1'b1;
        bus.penable = 1'b1;
        bus.pwrite  = 1'b1;
        bus.paddr   = 4'd4;
        bus.pwdata  = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge pclk);
            check("noset_pready", bus.pready, 1'b0);
            check("noset_state", state_o, 2'd0);
        end
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        @(negedge pclk);
        xfer(1'b0, 4'd4, 8'h00);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 The block SHALL have parameter AWIDTH, default 4, which is the address width in bits.
REQ-002 The block SHALL have parameter DWIDTH, default 8, which is the data width in bits.
REQ-003 The block SHALL have parameter NUM_REGS, default 12, which is the number of implemented registers, legal range 1..2^AWIDTH.
REQ-004 The block SHALL have port pclk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-005 The block SHALL have port presetn, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port psel, input, 1 bit: slave select.
REQ-007 The block SHALL have port penable, input, 1 bit: access-phase strobe.
REQ-008 The block SHALL have port pwrite, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port paddr, input, AWIDTH bits: register address.
REQ-010 The block SHALL have port pwdata, input, DWIDTH bits: write data.
REQ-011 The block SHALL have port prdata, output, DWIDTH bits: registered read data.
REQ-012 The block SHALL have port pready, output, 1 bit: transfer-complete indication.
REQ-013 The block SHALL have port pslverr, output, 1 bit: error response, valid only while pready=1.

Function
REQ-014 The block SHALL contain NUM_REGS registers of DWIDTH bits, addressed 0..NUM_REGS-1.
REQ-015 The FSM SHALL have the states IDLE, WAIT and ACCESS; WAIT exists only when APB_SLAVE_WAIT_EN is defined.
REQ-016 In IDLE, at an edge with psel=1 and penable=0 (setup phase), the block SHALL capture paddr, pwrite and pwdata, and SHALL register addr_err = (paddr >= NUM_REGS).
REQ-017 At that same IDLE setup edge, the FSM SHALL move to ACCESS, or to WAIT when APB_SLAVE_WAIT_EN is defined.
REQ-018 At the setup edge of a read, prdata SHALL load reg[paddr], or 0 if addr_err; prdata SHALL hold its value until the next read setup edge, and writes SHALL NOT alter prdata.
REQ-019 In IDLE, penable=1 without a preceding setup phase SHALL be ignored: the FSM stays in IDLE and pready stays 0.
REQ-020 pready SHALL be 1 exactly when the FSM is in ACCESS (decoded from state, no combinational path from inputs); pslverr SHALL be pready AND the captured addr_err.
REQ-021 At the ACCESS edge with psel=1 and penable=1, a write with addr_err=0 SHALL update reg[captured addr] with the captured pwdata, and the FSM SHALL return to IDLE.
REQ-022 A write with addr_err=1 SHALL update no register.
REQ-023 Back-to-back transfers SHALL be supported: a setup phase in the cycle immediately after completion is accepted from IDLE, giving a 2-cycle transfer without wait states.
REQ-024 If psel=0 or penable=0 in WAIT or ACCESS (an aborted transfer), the FSM SHALL return to IDLE with no register write and pslverr=0.
REQ-025 Address wrap is not applicable: addresses NUM_REGS..2^AWIDTH-1 always produce pslverr and are never aliased.

Reset
REQ-026 When presetn=0, the block SHALL immediately and asynchronously set the FSM to IDLE, all registers to 0, prdata to 0, pready to 0 and pslverr to 0.
REQ-027 A reset asserted mid-transfer SHALL discard the transfer; no write is committed.
REQ-028 The first setup phase SHALL be recognised at the first rising edge after presetn deasserts.

Configuration
REQ-029 With macro APB_SLAVE_WAIT_EN defined, every transfer SHALL pass through WAIT for exactly one cycle with pready=0 before ACCESS, giving 3 cycles per transfer.
REQ-030 With APB_SLAVE_WAIT_EN undefined, the WAIT state and its logic SHALL be absent and transfers SHALL take 2 cycles.

Verification
REQ-031 The bench SHALL cover: reset, then write addr 3 = 8'hA5, then read addr 3 -> prdata = 8'hA5, pslverr = 0, and pready high for exactly 1 cycle per transfer.
REQ-032 The bench SHALL cover: write addr 13 = 8'hFF (NUM_REGS = 12), then read addr 13 -> pslverr = 1 on both transfers, prdata = 8'h00, and registers 0..11 unchanged.
REQ-033 The bench SHALL cover: back-to-back writes to addrs 0..11 with data = addr+1, then reads -> each read returns addr+1, each transfer takes 2 cycles (3 with APB_SLAVE_WAIT_EN).
REQ-034 The bench SHALL cover: psel dropped during ACCESS of a write of 8'h3C to addr 5 -> reg[5] keeps its old value and the FSM returns to IDLE.
REQ-035 The bench SHALL cover: presetn pulsed low during ACCESS of a write of 8'h77 to addr 2 -> outputs go to 0 immediately and a subsequent read of addr 2 returns 8'h00.
REQ-036 The bench SHALL cover: penable=1 with psel=1 and no setup phase -> pready stays 0 and no register changes.
